// File: rtl/avalon_block_reader_pkg.sv
// Shared definitions for the Avalon block reader: FSM state encodings and
// output-buffer sizing. The buffer depth follows AVALON_READER_FIFO4_EN:
// defined -> 4-entry FIFO, undefined -> single-register buffer.
package avalon_block_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EMITIR  = 2'd1,
    S_ESPERAR = 2'd2,
    S_FIN     = 2'd3
  } state_e;

`ifdef AVALON_READER_FIFO4_EN
  localparam int BUF_DEPTH = 4;
`else
  localparam int BUF_DEPTH = 1;
`endif

  // Occupancy counter width, wide enough to hold the value BUF_DEPTH itself.
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/avalon_block_reader_fifo.sv
// reader_fifo: small synchronous FIFO holding words read from the slave until
// the downstream consumer takes them. Head word is presented combinationally
// from storage; a push and pop in the same cycle keep the occupancy constant.
module reader_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  // Storage is sized to the full pointer range so every pointer value indexes
  // a real entry; pointers still wrap at DEPTH-1.
  localparam int MEM_N = 1 << PTR_W;

  logic [WIDTH-1:0] mem_q [MEM_N];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Qualify push/pop so an empty pop or an overflowing push cannot corrupt state.
  always_comb begin
    pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}});
    push_ok_s = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok_s);
  end

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_N; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != {CNT_W{1'b0}});
  assign count_o = count_q;

endmodule

// File: rtl/avalon_block_reader.sv
// avalon_block_reader: reads `cantidad` consecutive words starting at
// `direccion_base` through an Avalon master stage, one read outstanding at a
// time, and streams them out through reader_fifo with valid/ready handshake.
// Build option: AVALON_READER_FIFO4_EN selects a 4-entry output FIFO instead
// of a single-register buffer; the interface is unchanged.
module avalon_block_reader
  import avalon_block_reader_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int ADDRESS_BITS = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    iniciar,
  input  logic [ADDRESS_BITS-1:0] direccion_base,
  input  logic [ADDRESS_BITS-1:0] cantidad,
  output logic                    ocupado,
  output logic                    terminado,
  output logic                    leer,
  output logic                    escribir,
  output logic [ADDRESS_BITS-1:0] direccion,
  output logic [DATA_BITS-1:0]    datos_escribir,
  input  logic [DATA_BITS-1:0]    datos_leidos,
  input  logic                    transaccion_completada,
  output logic [DATA_BITS-1:0]    dato_salida,
  output logic                    dato_valido,
  input  logic                    dato_listo
);

  state_e                  state_q;
  logic                    leer_q;
  logic                    ocupado_q;
  logic                    terminado_q;
  logic [ADDRESS_BITS-1:0] direccion_q;
  logic [ADDRESS_BITS-1:0] restante_q;

  logic                    push_s;
  logic                    pop_s;
  logic [BUF_CNT_W-1:0]    fifo_count_s;
  logic [BUF_CNT_W-1:0]    fifo_count_d;
  logic                    slot_free_s;

  // A completion only counts while a read is outstanding; a pop is a handshake.
  always_comb begin
    push_s = (state_q == S_ESPERAR) && transaccion_completada;
    pop_s  = dato_valido && dato_listo;
  end

  // Occupancy after this edge, so the registered leer never overfills the buffer.
  always_comb begin
    fifo_count_d = fifo_count_s;
    if (push_s && !pop_s) begin
      fifo_count_d = fifo_count_s + BUF_CNT_W'(1);
    end else if (!push_s && pop_s) begin
      fifo_count_d = fifo_count_s - BUF_CNT_W'(1);
    end else begin
      fifo_count_d = fifo_count_s;
    end
    slot_free_s = (fifo_count_d < BUF_CNT_W'(BUF_DEPTH));
  end

  // Job FSM with registered leer/ocupado/terminado/direccion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      leer_q      <= 1'b0;
      ocupado_q   <= 1'b0;
      terminado_q <= 1'b0;
      direccion_q <= {ADDRESS_BITS{1'b0}};
      restante_q  <= {ADDRESS_BITS{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          terminado_q <= 1'b0;
          leer_q      <= 1'b0;
          if (iniciar) begin
            direccion_q <= direccion_base;
            restante_q  <= cantidad;
            ocupado_q   <= 1'b1;
            if (cantidad == {ADDRESS_BITS{1'b0}}) begin
              state_q     <= S_FIN;
              terminado_q <= 1'b1;
            end else begin
              state_q <= S_EMITIR;
              leer_q  <= slot_free_s;
            end
          end else begin
            ocupado_q <= 1'b0;
          end
        end
        S_EMITIR: begin
          // leer_q high means the request is on the bus this cycle.
          if (leer_q) begin
            leer_q  <= 1'b0;
            state_q <= S_ESPERAR;
          end else begin
            leer_q <= slot_free_s;
          end
        end
        S_ESPERAR: begin
          if (transaccion_completada) begin
            direccion_q <= direccion_q + ADDRESS_BITS'(1);
            restante_q  <= restante_q - ADDRESS_BITS'(1);
            if (restante_q == ADDRESS_BITS'(1)) begin
              state_q     <= S_FIN;
              terminado_q <= 1'b1;
            end else begin
              state_q <= S_EMITIR;
              leer_q  <= slot_free_s;
            end
          end
        end
        S_FIN: begin
          // Buffered words keep draining on their own; the job is over.
          terminado_q <= 1'b0;
          ocupado_q   <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          leer_q      <= 1'b0;
          ocupado_q   <= 1'b0;
          terminado_q <= 1'b0;
        end
      endcase
    end
  end

  reader_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_s),
    .push_data_i (datos_leidos),
    .pop_i       (pop_s),
    .head_o      (dato_salida),
    .valid_o     (dato_valido),
    .count_o     (fifo_count_s)
  );

  assign leer           = leer_q;
  assign ocupado        = ocupado_q;
  assign terminado      = terminado_q;
  assign direccion      = direccion_q;
  assign escribir       = 1'b0;
  assign datos_escribir = {DATA_BITS{1'b0}};

endmodule

// File: doc/avalon_block_reader.md
AVALON_BLOCK_READER -- requirements
Module: avalon_block_reader

Interface
REQ-001 Parameter DATA_BITS, default 8, width of read words.
REQ-002 Parameter ADDRESS_BITS, default 5, width of addresses and transfer count.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 iniciar  in  1  one-cycle start request.
REQ-006 direccion_base  in  ADDRESS_BITS  first address, sampled when the start is accepted.
REQ-007 cantidad  in  ADDRESS_BITS  number of words to read, sampled when the start is accepted.
REQ-008 ocupado  out  1  high from the cycle after start acceptance until terminado.
REQ-009 terminado  out  1  one-cycle pulse when the job ends.
REQ-010 leer  out  1  read request to the Avalon master stage.
REQ-011 escribir  out  1  constant 0.
REQ-012 direccion  out  ADDRESS_BITS  read address to the master stage.
REQ-013 datos_escribir  out  DATA_BITS  constant 0.
REQ-014 datos_leidos  in  DATA_BITS  read data from the master stage; valid while transaccion_completada is high.
REQ-015 transaccion_completada  in  1  one-cycle completion pulse from the master stage.
REQ-016 dato_salida  out  DATA_BITS  head word of the output buffer.
REQ-017 dato_valido  out  1  output buffer is not empty.
REQ-018 dato_listo  in  1  downstream accepts dato_salida when dato_valido=1 and dato_listo=1.

Function
REQ-019 The FSM SHALL have exactly four states: S_IDLE, S_EMITIR, S_ESPERAR and S_FIN.
REQ-020 In S_IDLE with iniciar=1, the block SHALL latch direccion_base and cantidad, then go to S_FIN if cantidad=0 and to S_EMITIR otherwise.
REQ-021 iniciar SHALL be ignored in every state except S_IDLE.
REQ-022 In S_EMITIR with free buffer slots > 0, the block SHALL drive leer=1 and direccion=current address for exactly one cycle, then go to S_ESPERAR.
REQ-023 In S_EMITIR with a full buffer, leer SHALL stay 0 and the state SHALL be held.
REQ-024 In S_ESPERAR, leer SHALL be 0 and direccion SHALL hold the issued address.
REQ-025 In S_ESPERAR, a transaccion_completada pulse SHALL push datos_leidos into the buffer, increment the address modulo 2^ADDRESS_BITS, decrement the remaining count, and go to S_FIN if the count reaches 0, else to S_EMITIR.
REQ-026 At most one read SHALL be outstanding at any time, so a push never finds the buffer full.
REQ-027 S_FIN SHALL assert terminado for one cycle, then return to S_IDLE; it SHALL NOT wait for the buffer to drain.
REQ-028 Latency with zero wait-request: iniciar at cycle 0 -> leer at cycle 1 -> completion at cycle 3 -> dato_valido=1 at cycle 4.
REQ-029 The next leer SHALL be issued no earlier than the cycle after transaccion_completada.
REQ-030 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve word order.
REQ-031 transaccion_completada outside S_ESPERAR SHALL be ignored.
REQ-032 The buffer SHALL be strictly FIFO; dato_salida SHALL hold its value while dato_valido=1 and dato_listo=0.

Reset
REQ-033 While reset_n=0, the block SHALL hold state S_IDLE and drive leer=0, ocupado=0, terminado=0, dato_valido=0, direccion=0 and dato_salida=0, with buffer, address and count registers cleared.
REQ-034 Reset asserted mid-job SHALL abort the job immediately and discard buffered words, with no terminado pulse.

Configuration
REQ-035 With AVALON_READER_FIFO4_EN defined, the output buffer SHALL be a 4-entry FIFO.
REQ-036 Without AVALON_READER_FIFO4_EN, the output buffer SHALL be a single register, so each read waits for the previous word to be consumed; ports and all other behaviour SHALL be identical.

Structure
REQ-037 A shared package SHALL hold the state encodings S_IDLE=0, S_EMITIR=1, S_ESPERAR=2 and S_FIN=3, and the buffer-depth constant.
REQ-038 The output buffer SHALL be one sub-module, reader_fifo, parameterised by width and depth.

Verification
REQ-039 base=5, cantidad=3, slave with no wait, dato_listo=1 -> leer at addresses 5, 6, 7; three words out in order; one terminado pulse; ocupado low afterwards.
REQ-040 base=30, cantidad=4, ADDRESS_BITS=5 -> addresses 30, 31, 0, 1.
REQ-041 cantidad=0 -> terminado one cycle after start acceptance; leer never asserted.
REQ-042 dato_listo=0 with FIFO4 enabled, cantidad=6 -> exactly 4 reads, leer then stalls; raising dato_listo resumes reads 5 and 6 and emits all 6 words in order.
REQ-043 Slave wait-request held 3 cycles per read -> leer pulses once per word; iniciar pulsed while busy is ignored.
REQ-044 reset_n low during S_ESPERAR of word 2 -> all outputs return to their reset values immediately and no terminado pulse occurs.
